// File: rtl/block_note_sequencer.sv
// Latches a block of up to MAX_NOTES note codes and plays them out serially, each held for dur cycles.
// Optional feature: define NOTE_REST_GAP_EN to insert GAP_CYCLES rest cycles between consecutive notes.
module block_note_sequencer #(
  parameter int MAX_NOTES  = 4,
  parameter int NOTE_W     = 16,
  parameter int DUR_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [$clog2(MAX_NOTES+1)-1:0]   block_size,
  input  logic [MAX_NOTES*NOTE_W-1:0]      notes_in,
  input  logic [DUR_W-1:0]                 dur,
  output logic                             ready,
  output logic [MAX_NOTES*NOTE_W-1:0]      note_bus,
  output logic [NOTE_W-1:0]                play_note,
  output logic                             play_valid,
  output logic [$clog2(MAX_NOTES)-1:0]     play_idx,
  output logic                             done
);

  localparam int BS_W  = $clog2(MAX_NOTES + 1);
  localparam int IDX_W = $clog2(MAX_NOTES);

  if (GAP_CYCLES < 0) begin : g_gap_check
    $error("GAP_CYCLES must be non-negative");
  end

`ifdef NOTE_REST_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [DUR_W-1:0]    cnt_reg, cnt_next;
  logic [DUR_W-1:0]    dur_reg, dur_next;
  logic [BS_W-1:0]     n_reg, n_next;
  logic                done_reg, done_next;
  logic [NOTE_W-1:0]   notes_reg  [MAX_NOTES];
  logic [NOTE_W-1:0]   notes_next [MAX_NOTES];
`ifdef NOTE_REST_GAP_EN
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
`endif

  logic                accept;
  logic [BS_W-1:0]     n_clamped;
  logic [DUR_W-1:0]    dur_eff;
  logic [BS_W-1:0]     idx_ext;
  logic                last_note;

  assign accept    = load && (state_reg == IDLE);
  assign n_clamped = (block_size > BS_W'(MAX_NOTES)) ? BS_W'(MAX_NOTES) : block_size;
  assign dur_eff   = (dur == '0) ? DUR_W'(1) : dur;
  assign idx_ext   = BS_W'(idx_reg);
  assign last_note = ((idx_ext + BS_W'(1)) == n_reg);

  // Channels beyond the clamped block size are latched as zero so note_bus reads clean.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_NOTES; gi++) begin : g_ch
      assign notes_next[gi] = (BS_W'(gi) < n_clamped) ? notes_in[gi*NOTE_W +: NOTE_W] : '0;
      assign note_bus[gi*NOTE_W +: NOTE_W] = notes_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_NOTES; k++) notes_reg[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < MAX_NOTES; k++) notes_reg[k] <= notes_next[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      dur_reg     <= '0;
      n_reg       <= '0;
      done_reg    <= 1'b0;
`ifdef NOTE_REST_GAP_EN
      gap_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      dur_reg     <= dur_next;
      n_reg       <= n_next;
      done_reg    <= done_next;
`ifdef NOTE_REST_GAP_EN
      gap_cnt_reg <= gap_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    dur_next     = dur_reg;
    n_next       = n_reg;
    done_next    = 1'b0;
`ifdef NOTE_REST_GAP_EN
    gap_cnt_next = gap_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (load) begin
          n_next   = n_clamped;
          dur_next = dur_eff;
          idx_next = '0;
          if (n_clamped != '0) begin
            state_next = PLAY;
            cnt_next   = dur_eff;
          end else begin
            // An empty block completes immediately.
            done_next = 1'b1;
          end
        end
      end
      PLAY: begin
        if (cnt_reg == DUR_W'(1)) begin
          if (last_note) begin
            state_next = IDLE;
            idx_next   = '0;
            cnt_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
`ifdef NOTE_REST_GAP_EN
            if (GAP_CYCLES > 0) begin
              state_next   = GAP;
              gap_cnt_next = GAP_W'(GAP_CYCLES);
              cnt_next     = '0;
            end else begin
              cnt_next = dur_reg;
            end
`else
            cnt_next = dur_reg;
`endif
          end
        end else begin
          cnt_next = cnt_reg - DUR_W'(1);
        end
      end
`ifdef NOTE_REST_GAP_EN
      GAP: begin
        if (gap_cnt_reg == GAP_W'(1)) begin
          state_next   = PLAY;
          cnt_next     = dur_reg;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign ready      = (state_reg == IDLE);
  assign play_valid = (state_reg == PLAY);
  assign play_note  = play_valid ? notes_reg[idx_reg] : '0;
  assign play_idx   = idx_reg;
  assign done       = done_reg;

endmodule
